axi4s_sram: RTL and testbench
=============================

# axi4s_sram

AXI4 slave bridge that accepts single-beat and burst transactions from an AXI4 interconnect and turns each beat into one request on the core's native val/rdy memory port. It is the responder-side counterpart of the core's AXI4 master bridge and sits in front of on-chip SRAM and peripheral blocks that expose the native port. It handles one transaction at a time, with no outstanding reads or writes.

## Interface
- AXI_ADDR_W, 32: AXI address width; native `adr` uses the low 32 bits.
- AXI_DATA_W, 32: AXI data width; fixed at 32 to match the native port.
- ID_W, 4: AXI ID width; IDs are echoed on the B and R channels.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/AXI_ADDR_W/8/3/2  write address.
  - awlock/awcache/awprot/awqos: accepted and ignored.
- s_axi_awvalid  in  1.
- s_axi_awready  out  1.
- s_axi_wdata  in  32.
- s_axi_wstrb  in  4.
- s_axi_wlast  in  1.
- s_axi_wvalid  in  1.
- s_axi_wready  out  1.
- s_axi_bid  out  ID_W.
- s_axi_bresp  out  2.
- s_axi_bvalid  out  1.
- s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/AXI_ADDR_W/8/3/2  read address.
  - arlock/arcache/arprot/arqos: accepted and ignored.
- s_axi_arvalid  in  1.
- s_axi_arready  out  1.
- s_axi_rid  out  ID_W.
- s_axi_rdata  out  32.
- s_axi_rresp  out  2.
- s_axi_rlast  out  1.
- s_axi_rvalid  out  1.
- s_axi_rready  in  1.
- val  out  1  native request valid.
- rdy  in  1  native request complete; the request completes on `val & rdy`.
- adr  out  32  native word address, {addr[31:2], 2'b00}.
- wen  out  4  byte write enables; all zero means a read.
- wdat  out  32  write data.
- rdat  in  32  read data, valid only in the cycle where `val & rdy` holds for a read.

## Operation
- FSM states: IDLE, WDATA, WRESP, RREQ, RDATA (3-bit encoding).
- **IDLE arbitration.**
  - If only one of awvalid/arvalid is high, that request is granted.
  - If both are high, the request type not granted last time wins. A 1-bit `last_rd` flag tracks this; reset value is 1, so a write wins first.
- **Grant.**
  - `awready` or `arready` is asserted combinationally, in IDLE only, for the granted channel.
  - On the handshake, latch id, addr, len and burst; clear the beat counter and `err`.
- **Burst validity.**
  - Burst type INCR (01): address += 4 per beat.
  - Burst type FIXED (00): address is held.
  - Burst type WRAP (10): see Configuration.
  - Burst type 11 is unsupported.
  - awsize/arsize are ignored; every beat is 32 bits.
- **WDATA.**
  - `val = wvalid`, `wready = rdy`, `wen = wstrb`, `wdat = wdata`.
  - On `wvalid & rdy`: advance the address and increment the counter.
  - If `wlast != (cnt == len)`, set `err`.
  - When `cnt == len`, go to WRESP. The beat count terminates the burst, not wlast.
- **WRESP.**
  - `bvalid = 1`, `bid` = latched id, `bresp = err ? 2'b10 : 2'b00`.
  - On bready, go to IDLE.
- **RREQ.**
  - `val = 1`, `wen = 0`.
  - On rdy, capture rdat into `rbuf` and go to RDATA.
- **RDATA.**
  - `rvalid = 1`, `rdata = rbuf`, `rid` = latched id, `rlast = (cnt == len)`, `rresp = 2'b00`.
  - On rready: if rlast, go to IDLE; otherwise advance the address, increment the counter and go to RREQ.
- **Unsupported burst (SLVERR path).**
  - No native access is made.
  - Writes: `wready = 1`, data discarded, `bresp = 2'b10`.
  - Reads: RDATA returns len+1 beats with `rdata = 0` and `rresp = 2'b10`, going RDATA→RDATA without passing through RREQ.
- **Address arithmetic.** Modulo 2^32; wrap-around past 0xFFFFFFFC rolls to 0 without an error.

## Timing
- **Reset values.**
  - All valid/ready outputs are 0; `val` is 0.
  - bresp, rresp, rdata, rid, bid are 0; rlast is 0.
  - FSM is in IDLE; `last_rd = 1`.
  - Reset mid-burst abandons the transaction with no B or R response.
- **Read beat latency.**
  - AR handshake at cycle N puts the FSM in RREQ at N+1.
  - With rdy at N+1, rvalid is high at N+2.
  - Each later beat costs at least 2 cycles.
- **Write beat.** One cycle per beat when wvalid and rdy are both high. bvalid rises the cycle after the last beat.
- **Output stability.** rvalid/rdata and bvalid/bresp are registered and held stable until their handshake.
- **No early acceptance.** awready and arready are never high outside IDLE; a new AW/AR is not accepted in the cycle B or the last R completes.

## Configuration
- `AXI4S_WRAP_EN` defined:
  - WRAP bursts with len ∈ {1,3,7,15} are supported, with `mask = (len+1)*4 - 1` and next address `(addr & ~mask) | ((addr+4) & mask)`.
  - WRAP with any other len takes the SLVERR path.
- `AXI4S_WRAP_EN` undefined: every WRAP burst takes the SLVERR path.

## Test plan
- **Single write.** AW addr 0x100 len 0, W 0xDEADBEEF strb 0xF wlast, rdy held 1 -> one native write, adr 0x100 wen 0xF; then bresp 00 with bid echoed.
- **Incr read.** AR 0x200 len 3, rdy held 1 -> native reads at 0x200/204/208/20C; 4 R beats, rlast only on the 4th; rresp 00.
- **Backpressure.** Same 4-beat read with rready low 3 cycles per beat and rdy delayed 2 cycles -> rdata stable while rvalid is high; no beat lost or duplicated.
- **Arbitration.** AW and AR asserted in the same cycle after reset -> write granted first, read granted next; repeat with both asserted -> the alternation holds.
- **Wlast mismatch.** len 1 write with wlast on beat 0 -> 2 native writes; bresp 10.
- **WRAP burst.**
  - With `AXI4S_WRAP_EN`: read 0x10C len 3 -> addresses 0x10C, 0x100, 0x104, 0x108.
  - Without it: 4 beats with rresp 10, rdata 0, val never asserted.

Source files
------------

// File: rtl/axi4s_sram.sv
// axi4s_sram: AXI4 slave bridge turning each burst beat into one native val/rdy memory request.
// Ports: clk/rst; s_axi_aw*/w*/b* write channels, s_axi_ar*/r* read channels;
// val/rdy/adr/wen/wdat/rdat native memory port. One transaction in flight at a time.
// Optional feature macro: AXI4S_WRAP_EN enables WRAP bursts of 2/4/8/16 beats.
module axi4s_sram #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int ID_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [AXI_DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_W-1:0]       s_axi_arid,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_W-1:0]       s_axi_rid,
    output logic [AXI_DATA_W-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  val,
    input  logic                  rdy,
    output logic [31:0]           adr,
    output logic [3:0]            wen,
    output logic [31:0]           wdat,
    input  logic [31:0]           rdat
);
    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RDATA} state_t;
    state_t          state_q, state_d;
    logic            last_rd_q, last_rd_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     addr_q, addr_d, rbuf_q, rbuf_d, addr_nxt;
    logic [7:0]      len_q, len_d, cnt_q, cnt_d, len_in;
    logic [1:0]      burst_q, burst_d, burst_in;
    logic            err_q, err_d, bad_q, bad_d;
    logic            idle, gnt_w, gnt_r, last, wrap_ok, bad_in;
    logic            unused_ok;
    assign unused_ok = ^{s_axi_awsize, s_axi_arsize, s_axi_awlock, s_axi_arlock, s_axi_awcache,
                         s_axi_arcache, s_axi_awprot, s_axi_arprot, s_axi_awqos, s_axi_arqos};
    assign idle     = state_q == IDLE;
    // A write wins a tie only if the previous grant was a read.
    assign gnt_w    = idle && s_axi_awvalid && (!s_axi_arvalid || last_rd_q);
    assign gnt_r    = idle && s_axi_arvalid && !gnt_w;
    assign len_in   = gnt_w ? s_axi_awlen : s_axi_arlen;
    assign burst_in = gnt_w ? s_axi_awburst : s_axi_arburst;
    assign last     = cnt_q == len_q;
`ifdef AXI4S_WRAP_EN
    assign wrap_ok  = len_in == 8'd1 || len_in == 8'd3 || len_in == 8'd7 || len_in == 8'd15;
    // (len+1)*4-1 is simply len with two low one bits appended.
    assign addr_nxt = burst_q == 2'b00 ? addr_q :
                      burst_q == 2'b10 ? (addr_q & ~{22'd0, len_q, 2'b11}) |
                                         ((addr_q + 32'd4) & {22'd0, len_q, 2'b11}) :
                                         addr_q + 32'd4;
`else
    assign wrap_ok  = 1'b0;
    assign addr_nxt = burst_q == 2'b00 ? addr_q : addr_q + 32'd4;
`endif
    assign bad_in   = burst_in[1] && !(!burst_in[0] && wrap_ok);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bad_q     <= 1'b0;
            rbuf_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            bad_q     <= bad_d;
            rbuf_q    <= rbuf_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        bad_d     = bad_q;
        rbuf_d    = rbuf_q;
        case (state_q)
            IDLE: if (gnt_w || gnt_r) begin
                // Unsupported reads skip the native side and go straight to error beats.
                state_d   = gnt_w ? WDATA : bad_in ? RDATA : RREQ;
                last_rd_d = gnt_r;
                id_d      = gnt_w ? s_axi_awid : s_axi_arid;
                addr_d    = gnt_w ? s_axi_awaddr[31:0] : s_axi_araddr[31:0];
                len_d     = len_in;
                burst_d   = burst_in;
                cnt_d     = '0;
                err_d     = bad_in;
                bad_d     = bad_in;
                rbuf_d    = '0;
            end
            WDATA: if (s_axi_wvalid && s_axi_wready) begin
                addr_d  = addr_nxt;
                cnt_d   = cnt_q + 8'd1;
                err_d   = err_q || (s_axi_wlast != last);
                state_d = last ? WRESP : WDATA;
            end
            WRESP: state_d = s_axi_bready ? IDLE : WRESP;
            RREQ: if (rdy) begin
                rbuf_d  = rdat;
                state_d = RDATA;
            end
            RDATA: if (s_axi_rready) begin
                state_d = last ? IDLE : bad_q ? RDATA : RREQ;
                addr_d  = last ? addr_q : addr_nxt;
                cnt_d   = last ? cnt_q : cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        s_axi_awready = gnt_w;
        s_axi_arready = gnt_r;
        s_axi_wready  = state_q == WDATA && (bad_q || rdy);
        s_axi_bvalid  = state_q == WRESP;
        s_axi_bid     = id_q;
        s_axi_bresp   = {err_q, 1'b0};
        s_axi_rvalid  = state_q == RDATA;
        s_axi_rid     = id_q;
        s_axi_rdata   = rbuf_q;
        s_axi_rresp   = {err_q, 1'b0};
        s_axi_rlast   = state_q == RDATA && last;
        val           = (state_q == WDATA && !bad_q && s_axi_wvalid) || state_q == RREQ;
        adr           = {addr_q[31:2], 2'b00};
        wen           = state_q == WDATA && !bad_q ? s_axi_wstrb : 4'b0;
        wdat          = s_axi_wdata;
    end
endmodule

// File: tb/tb_axi4s_sram.sv
// tb_axi4s_sram: randomized self-checking bench for axi4s_sram against a transaction-level model.
module tb_axi4s_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata, adr, wdat, rdat;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awlock = 1'b0, arlock = 1'b0;
    logic [3:0]  awcache = '0, arcache = '0, awqos = '0, arqos = '0;
    logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        bready = 1'b0, rready = 1'b0, rdy = 1'b0;
    logic [3:0]  wstrb = '0, wen;
    logic        awready, arready, wready, bvalid, rvalid, rlast, val;
    int          checks = 0, errors = 0, rdy_pct = 100, val_cycles = 0;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] acc_adr [$];
    logic [3:0]  acc_wen [$];
    logic [31:0] acc_wdat [$];

    axi4s_sram dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
        .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
        .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .val(val), .rdy(rdy), .adr(adr), .wen(wen), .wdat(wdat), .rdat(rdat)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fill(input int i);
        return 32'(i) * 32'h0101_0101 ^ 32'hA500_0000;
    endfunction

    // SRAM behind the bridge: random rdy, combinational read data, byte-enabled writes.
    assign rdat = mem[adr[11:2]];
    always @(negedge clk) rdy = $urandom_range(99) < rdy_pct;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= fill(i);
        end else begin
            if (val) val_cycles <= val_cycles + 1;
            if (val && rdy) begin
                acc_adr.push_back(adr);
                acc_wen.push_back(wen);
                acc_wdat.push_back(wdat);
                for (int b = 0; b < 4; b++) if (wen[b]) mem[adr[11:2]][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit supported(input logic [1:0] burst, input logic [7:0] len);
`ifdef AXI4S_WRAP_EN
        return burst < 2'd2 || (burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15));
`else
        return burst < 2'd2;
`endif
    endfunction

    // Address of beat k: FIXED holds, INCR steps by 4, WRAP cycles within an aligned window.
    function automatic logic [31:0] exp_adr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [1:0] burst, input int k);
        logic [31:0] size, base, r;
        size = ({24'd0, len} + 32'd1) * 32'd4;
        base = a - (a % size);
        r = burst == 2'b00 ? a : burst == 2'b01 ? a + 32'(k * 4) : base + ((a - base + 32'(k * 4)) % size);
        return {r[31:2], 2'b00};
    endfunction

    function automatic bit sig(input int w);
        return w == 0 ? awready : w == 1 ? arready : w == 2 ? wready : rvalid;
    endfunction

    task automatic wait_for(input int w, input string tag, output int n);
        n = 0;
        #1;
        while (!sig(w) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(sig(w)), 64'd1);
    endtask

    task automatic hs(input int w, input string tag);
        int n;
        wait_for(w, tag, n);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctl", 64'({awready, arready, wready, bvalid, rvalid, rlast, val}), 64'd0);
        chk("reset_dat", 64'({bresp, rresp, rid, bid, rdata}), 64'd0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = fill(i);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input int wl_beat);
        bit          sup = supported(burst, len);
        bit          err = !sup;
        int          base = acc_adr.size();
        int          vc0 = val_cycles;
        logic [31:0] ea, d, ea_q[$], d_q[$];
        logic [3:0]  s, s_q[$];
        awid = id; awaddr = a; awlen = len; awburst = burst; awsize = 3'($urandom); awvalid = 1'b1;
        hs(0, "aw_hs");
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            wdata = d; wstrb = s; wlast = k == wl_beat; wvalid = 1'b1;
            if (wlast != (k == int'(len))) err = 1'b1;
            if (sup) begin
                ea = exp_adr(a, len, burst, k);
                for (int b = 0; b < 4; b++) if (s[b]) ref_mem[ea[11:2]][8*b +: 8] = d[8*b +: 8];
                ea_q.push_back(ea); d_q.push_back(d); s_q.push_back(s);
            end
            hs(2, "w_hs");
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        repeat ($urandom_range(0, 3)) begin
            chk("b_hold", 64'({bvalid, bresp, bid, awready, arready}), 64'({1'b1, err, 1'b0, id, 2'b00}));
            @(negedge clk);
            #1;
        end
        bready = 1'b1;
        chk("b_resp", 64'({bvalid, bresp, bid, awready, arready}), 64'({1'b1, err, 1'b0, id, 2'b00}));
        @(negedge clk);
        bready = 1'b0;
        #1;
        chk("b_done", 64'(bvalid), 64'd0);
        chk("w_nacc", 64'(acc_adr.size() - base), 64'(ea_q.size()));
        for (int i = 0; i < ea_q.size() && base + i < acc_adr.size(); i++)
            chk("w_acc", {acc_adr[base+i], acc_wen[base+i], 28'd0}, {ea_q[i], s_q[i], 28'd0});
        for (int i = 0; i < d_q.size() && base + i < acc_adr.size(); i++)
            chk("w_wdat", 64'(acc_wdat[base+i]), 64'(d_q[i]));
        if (!sup) chk("w_noval", 64'(val_cycles - vc0), 64'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_max);
        bit          sup = supported(burst, len);
        int          base = acc_adr.size();
        int          vc0 = val_cycles;
        int          n;
        logic [31:0] ea, ed;
        logic [39:0] beat;
        arid = id; araddr = a; arlen = len; arburst = burst; arsize = 3'($urandom); arvalid = 1'b1;
        hs(1, "ar_hs");
        arvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wait_for(3, "r_valid", n);
            if (k == 0 && sup && rdy_pct == 100) chk("r_latency", 64'(n), 64'd1);
            ea = exp_adr(a, len, burst, k);
            ed = sup ? ref_mem[ea[11:2]] : 32'd0;
            beat = {1'b1, ed, !sup, 1'b0, k == int'(len), id};
            repeat ($urandom_range(0, stall_max)) begin
                chk("r_hold", 64'({rvalid, rdata, rresp, rlast, rid}), 64'(beat));
                @(negedge clk);
                #1;
            end
            rready = 1'b1;
            chk("r_beat", 64'({rvalid, rdata, rresp, rlast, rid}), 64'(beat));
            chk("r_noacc", 64'({awready, arready}), 64'd0);
            @(negedge clk);
            rready = 1'b0;
        end
        #1;
        chk("r_done", 64'(rvalid), 64'd0);
        chk("r_nacc", 64'(acc_adr.size() - base), sup ? 64'(len) + 64'd1 : 64'd0);
        for (int k = 0; sup && k <= int'(len) && base + k < acc_adr.size(); k++)
            chk("r_acc", {acc_adr[base+k], acc_wen[base+k], 28'd0}, {exp_adr(a, len, burst, k), 4'd0, 28'd0});
        if (!sup) chk("r_noval", 64'(val_cycles - vc0), 64'd0);
    endtask

    initial begin
        int n;
        logic [7:0] len;
        do_reset();
        do_write(4'h3, 32'h100, 8'd0, 2'b01, 0);
        chk("sram_100", 64'(mem[64]), 64'(ref_mem[64]));
        do_read(4'h5, 32'h100, 8'd0, 2'b01, 0);
        do_read(4'h6, 32'h200, 8'd3, 2'b01, 0);
        rdy_pct = 35;
        do_read(4'h7, 32'h200, 8'd3, 2'b01, 3);
        rdy_pct = 100;
        // Arbitration: write first after reset, then alternate while both are requested.
        araddr = 32'h240; arlen = 8'd1; arburst = 2'b01; arvalid = 1'b1; awvalid = 1'b1;
        #1;
        chk("arb_w_first", 64'({awready, arready}), 64'b10);
        do_write(4'h1, 32'h240, 8'd1, 2'b01, 1);
        awaddr = 32'h280; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        #1;
        chk("arb_r_next", 64'({awready, arready}), 64'b01);
        do_read(4'h2, 32'h240, 8'd1, 2'b01, 1);
        arvalid = 1'b1;
        #1;
        chk("arb_w_again", 64'({awready, arready}), 64'b10);
        do_write(4'h4, 32'h280, 8'd0, 2'b01, 0);
        do_read(4'h8, 32'h240, 8'd1, 2'b01, 0);
        do_write(4'h9, 32'h300, 8'd1, 2'b01, 0);
        do_read(4'hA, 32'h10C, 8'd3, 2'b10, 1);
        do_write(4'hB, 32'h108, 8'd3, 2'b10, 3);
        do_write(4'hC, 32'h400, 8'd2, 2'b11, 2);
        do_read(4'hD, 32'h400, 8'd2, 2'b11, 1);
        do_write(4'hE, 32'h500, 8'd3, 2'b00, 3);
        do_read(4'hF, 32'h500, 8'd3, 2'b00, 0);
        do_write(4'h2, 32'hFFFF_FFF8, 8'd3, 2'b01, 3);
        do_read(4'h3, 32'hFFFF_FFF8, 8'd3, 2'b01, 0);
        for (int t = 0; t < 40; t++) begin
            rdy_pct = $urandom_range(30, 100);
            len = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_write(4'($urandom), $urandom, len, 2'($urandom_range(0, 3)),
                         $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 15)) : int'(len));
            else
                do_read(4'($urandom), $urandom, len, 2'($urandom_range(0, 3)), 2);
        end
        // Reset in the middle of a read burst abandons it without a response.
        rdy_pct = 100;
        arid = 4'h6; araddr = 32'h600; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        hs(1, "ar_hs_mid");
        arvalid = 1'b0;
        wait_for(3, "r_valid_mid", n);
        do_reset();
        chk("mid_rst_idle", 64'({rvalid, bvalid, val}), 64'd0);
        arvalid = 1'b1; awvalid = 1'b1; awaddr = 32'h700; awlen = 8'd0; awburst = 2'b01;
        #1;
        chk("arb_after_rst", 64'({awready, arready}), 64'b10);
        do_write(4'h5, 32'h700, 8'd0, 2'b01, 0);
        do_read(4'h5, 32'h700, 8'd0, 2'b01, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
